// File: rtl/shared_reg_arbiter_if.sv
// Request/grant bundle for shared_reg_arbiter.
// master = requesters side, slave = arbiter side.
interface shared_reg_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [DATA_W-1:0]       q_o;
    logic                    busy_o;
    logic                    timeout_o;

    modport master (
        output req_i, data_i,
        input  gnt_o, q_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, data_i,
        output gnt_o, q_o, busy_o, timeout_o
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter guarding one shared register.
// Define SHARED_REG_ARB_TIMEOUT_EN to bound each tenure to MAX_HOLD cycles.
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input logic             clk,
    input logic             reset,
    shared_reg_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(N_REQ);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] q_q, q_d;

    logic [DATA_W-1:0]  slice [N_REQ];
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [PTR_W-1:0]   off;
    logic [PTR_W:0]     sum;
    logic [PTR_W:0]     nxt;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   pick_nxt;
    logic               found;

`ifdef SHARED_REG_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slice[i] = bus.data_i[i*DATA_W +: DATA_W];
        end
    end

    // Rotate requests so offset 0 is rr_ptr, then take the lowest offset.
    always_comb begin
        req_dbl = {bus.req_i, bus.req_i} >> rr_ptr_q;
        req_rot = req_dbl[N_REQ-1:0];
        off     = '0;
        found   = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off   = PTR_W'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        pick = sum[PTR_W-1:0];
        nxt  = {1'b0, pick} + (PTR_W+1)'(1);
        if (nxt == NREQ_W) begin
            nxt = '0;
        end
        pick_nxt = nxt[PTR_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        q_d      = q_q;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = GRANT;
                    owner_d  = pick;
                    gnt_d    = N_REQ'(1) << pick;
                    rr_ptr_d = pick_nxt;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
                    hold_d = '0;
`endif
                end
            end
            GRANT: begin
                if (bus.req_i[owner_q]) begin
                    q_d = slice[owner_q];
`ifdef SHARED_REG_ARB_TIMEOUT_EN
                    hold_d = hold_q + HOLD_W'(1);
                    if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        timeout_d = 1'b1;
                    end
`endif
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            q_q      <= '0;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            q_q      <= q_d;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt_o  = gnt_q;
    assign bus.q_o    = q_q;
    assign bus.busy_o = |gnt_q;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif
endmodule
